// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding and product width.
package mult_pkg;

    localparam int DW_DEF = 16;
    localparam int PW     = 2 * DW_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [PW-1:0] product_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter: counts RUN steps and flags the last one (count == DW-1).
// Latency: tc is combinational from the count register.
// Backpressure: en low holds the count; clr has priority over en.
module mult_iter_counter #(
    parameter int DW = 16,
    parameter int CW = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(DW - 1));

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per enabled cycle.
// Latency: done pulses in the cycle after edge k+DW for start at edge k, plus one per enb-low RUN cycle.
// Backpressure: enb low freezes RUN; start is ignored while busy and never queued.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enb,
    input  logic            start,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);

    state_t state, state_nxt;

    logic [2*DW-1:0] a_reg;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] acc_sum;
    logic [2*DW-1:0] product_reg;
    logic [DW-1:0]   b_reg;
    logic            load;
    logic            step;
    logic            tc;

    mult_iter_counter #(
        .DW (DW),
        .CW (CW)
    ) u_iter_counter (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (step),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (enb) begin
                    step = 1'b1;
                    if (tc) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The final step's partial product must land in product, so take the sum, not acc.
    assign acc_sum = acc + (b_reg[0] ? a_reg : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            product_reg <= '0;
        end else if (load) begin
            a_reg <= {{DW{1'b0}}, multiplicand};
            b_reg <= multiplier;
            acc   <= '0;
        end else if (step) begin
            acc   <= acc_sum;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            if (tc) begin
                product_reg <= acc_sum;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised scoreboard bench for shift_add_multiplier against a plain a*b reference.
module tb_shift_add_multiplier;
    import mult_pkg::*;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enb = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   multiplicand = '0;
    logic [DW-1:0]   multiplier = '0;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] product;

    shift_add_multiplier #(.DW(DW), .CW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    int       n_chk  = 0;
    int       n_fail = 0;
    int       cyc    = 0;
    int       n_done = 0;
    int       n_ops  = 0;
    product_t sb_q[$];
    int       done_cyc_q[$];
    product_t last_prod = '0;
    logic     prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                n_done++;
                done_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(product), 64'hDEAD);
                end else begin
                    check("product", 64'(product), 64'(sb_q.pop_front()));
                end
                check("done_one_cycle", 64'(prev_done), 64'd0);
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    function automatic product_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return product_t'(a) * product_t'(b);
    endfunction

    // One operation; stall window [st0, st0+stn) in RUN edges; poke re-asserts start (7*7) mid-run.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int st0, input int stn, input bit rnd_enb, input bit poke);
        int edges;
        int stalls;
        @(negedge clk);
        enb          = 1'($urandom_range(0, 1));
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        sb_q.push_back(model(a, b));
        n_ops++;
        @(posedge clk);
        #1;
        check("busy_after_start", 64'(busy), 64'd1);
        edges  = 0;
        stalls = 0;
        while (1) begin
            @(negedge clk);
            start        = poke && (edges >= 3) && (edges < 8);
            multiplicand = poke ? 16'd7 : 16'($urandom);
            multiplier   = poke ? 16'd7 : 16'($urandom);
            if (rnd_enb) enb = ($urandom_range(0, 3) != 0);
            else         enb = !((edges - stalls >= st0) && (stalls < stn));
            if (!enb) stalls++;
            @(posedge clk);
            edges++;
            #1;
            if (done || edges > 400) break;
            if (edges == 8) check("product_stable_in_run", 64'(product), 64'(last_prod));
        end
        check("latency_edges", 64'(edges), 64'(DW + stalls));
        last_prod = model(a, b);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_after_done", 64'(done), 64'd0);
        check("product_hold", 64'(product), 64'(last_prod));
    endtask

    task automatic abort_op();
        @(negedge clk);
        enb = 1'b1; multiplicand = 16'd9; multiplier = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        last_prod = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(n_ops));
    endtask

    task automatic back_to_back();
        int guard;
        @(negedge clk);
        enb = 1'b1; multiplicand = 16'd2; multiplier = 16'd2; start = 1'b1;
        sb_q.push_back(model(16'd2, 16'd2));
        n_ops++;
        @(negedge clk);
        multiplicand = 16'd3; multiplier = 16'd3;
        sb_q.push_back(model(16'd3, 16'd3));
        n_ops++;
        guard = 0;
        while (n_done < n_ops && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check("b2b_timeout", 64'(guard < 200), 64'd1);
        if (done_cyc_q.size() >= 2)
            check("b2b_period", 64'(done_cyc_q[$] - done_cyc_q[$-1]), 64'(DW + 2));
        last_prod = model(16'd3, 16'd3);
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op(16'd3,      16'd5,      0, 0, 1'b0, 1'b0);
        do_op(16'hFFFF,   16'hFFFF,   0, 0, 1'b0, 1'b0);
        do_op(16'h0000,   16'h1234,   0, 0, 1'b0, 1'b0);
        do_op(16'h0012,   16'h0034,   4, 5, 1'b0, 1'b0);
        do_op(16'd2,      16'd3,      0, 0, 1'b0, 1'b1);
        check("poke_single_done", 64'(n_done), 64'(n_ops));
        do_op(16'd7,      16'd7,      0, 0, 1'b0, 1'b0);
        abort_op();
        do_op(16'd4,      16'd4,      0, 0, 1'b0, 1'b0);
        back_to_back();
        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("done_count", 64'(n_done), 64'(n_ops));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
